// File: rtl/tdm_demux16_pkg.sv
// tdm_demux16_pkg: shared constants, FSM encoding and channel-slice helper for the TDM demux.
package tdm_demux16_pkg;
    localparam int SLOT_W = 4;
    localparam int NCH = 16;
    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;
    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if: slotted-stream input and parallel-channel output bundle.
// drop_cnt exists only when TDM_DEMUX16_DROP_CNT_EN is defined.
interface tdm_demux16_if #(parameter int DATA_W = 1);
    import tdm_demux16_pkg::*;
    logic                    in_valid;
    logic                    in_sof;
    logic [DATA_W-1:0]       in_data;
    logic [NCH*DATA_W-1:0]   out;
    logic                    out_valid;
    logic [SLOT_W-1:0]       slot;
    logic                    frame_err;
`ifdef TDM_DEMUX16_DROP_CNT_EN
    logic [7:0]              drop_cnt;
`endif
    modport master(output in_valid, in_sof, in_data,
                   input out, out_valid, slot, frame_err
`ifdef TDM_DEMUX16_DROP_CNT_EN
                   , input drop_cnt
`endif
                  );
    modport slave(input in_valid, in_sof, in_data,
                  output out, out_valid, slot, frame_err
`ifdef TDM_DEMUX16_DROP_CNT_EN
                  , output drop_cnt
`endif
                 );
endinterface

// File: rtl/tdm_demux16_dec4to16.sv
// dec4to16: one-hot shadow write-enable decoder, gated by the beat-accept strobe.
module dec4to16
    import tdm_demux16_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    input  logic              en,
    output logic [NCH-1:0]    we
);
    always_comb we = en ? {{(NCH-1){1'b0}}, 1'b1} << sel : '0;
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: 16-slot TDM demux; assembles a frame in shadow regs and publishes it atomically.
// Optional TDM_DEMUX16_DROP_CNT_EN adds a saturating count of dropped beats and aborted frames.
module tdm_demux16
    import tdm_demux16_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input logic clk,
    input logic rst,
    tdm_demux16_if.slave bus
);
    state_t                state;
    logic [SLOT_W-1:0]     slot_q;
    logic [SLOT_W-1:0]     wsel;
    logic [NCH*DATA_W-1:0] shadow;
    logic [NCH*DATA_W-1:0] out_q;
    logic                  out_valid_q;
    logic                  frame_err_q;
    logic                  accept;
    logic                  last;
    logic                  early_sof;
    logic [NCH-1:0]        we;

    assign accept    = bus.in_valid & (bus.in_sof | state == RUN);
    assign early_sof = bus.in_valid & bus.in_sof & state == RUN;
    assign last      = bus.in_valid & ~bus.in_sof & state == RUN & slot_q == SLOT_W'(NCH - 1);
    assign wsel      = bus.in_sof ? '0 : slot_q;

    dec4to16 u_dec (.sel(wsel), .en(accept), .we(we));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot_q      <= '0;
            shadow      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= last;
            frame_err_q <= early_sof;
            for (int k = 0; k < NCH; k++)
                if (we[k]) shadow[ch_lo(k, DATA_W) +: DATA_W] <= bus.in_data;
            if (bus.in_valid && bus.in_sof) begin
                state  <= RUN;
                slot_q <= SLOT_W'(1);
            end else if (bus.in_valid && state == RUN) begin
                state  <= last ? HUNT : RUN;
                slot_q <= last ? '0 : slot_q + 1'b1;
            end
            // slot 15 bypasses the shadow so the frame publishes on the very next edge
            if (last) out_q <= {bus.in_data, shadow[(NCH-1)*DATA_W-1:0]};
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.frame_err = frame_err_q;

`ifdef TDM_DEMUX16_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q;
    assign drop = bus.in_valid & (bus.in_sof ? state == RUN : state == HUNT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
    assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: randomized scoreboard bench for tdm_demux16 (DATA_W=4) against a queue-based frame model.
// Define TDM_DEMUX16_DROP_CNT_EN to also check the drop counter.
module tb_tdm_demux16;
    typedef struct {
        logic [63:0] val;
        longint      t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tdm_demux16_if #(.DATA_W(4)) bus ();
    tdm_demux16 #(.DATA_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          chk = 0;
    int          errs = 0;
    int          drops = 0;
    logic [3:0]  coll[$];
    exp_t        exp_q[$];
    longint      err_q[$];
    logic [63:0] cur_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        chk++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Model: a frame is the list of beats collected since the last SOF; 16 beats publish it.
    task automatic model(input bit sof, input logic [3:0] d);
        exp_t e;
        if (sof) begin
            if (coll.size() > 0) begin
                err_q.push_back($time);
                drops++;
            end
            coll.delete();
            coll.push_back(d);
        end else if (coll.size() == 0) begin
            drops++;
        end else begin
            coll.push_back(d);
            if (coll.size() == 16) begin
                e.val = '0;
                for (int k = 0; k < 16; k++) e.val |= 64'(coll[k]) << (4 * k);
                e.t = $time;
                exp_q.push_back(e);
                coll.delete();
            end
        end
    endtask

    task automatic beat(input bit sof, input logic [3:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        model(sof, d);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int base, input int gap_after, input int gap);
        for (int k = 0; k < 16; k++) begin
            beat(k == 0, 4'((base + k) % 16));
            if (k == gap_after)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    #1 check("gap_slot", 64'(bus.slot), 64'(k + 1));
                end
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out", bus.out, 64'h0);
        check("rst_slot", 64'(bus.slot), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_frame_err", 64'(bus.frame_err), 64'h0);
        coll.delete();
        exp_q.delete();
        err_q.delete();
        drops   = 0;
        cur_out = '0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
`ifdef TDM_DEMUX16_DROP_CNT_EN
        check("rst_drop_cnt", 64'(bus.drop_cnt), 64'h0);
`endif
    endtask

    task automatic check_drops();
`ifdef TDM_DEMUX16_DROP_CNT_EN
        check("drop_cnt", 64'(bus.drop_cnt), 64'(drops > 255 ? 255 : drops));
`endif
    endtask

    // Monitor: compares outputs each cycle against the scoreboard queues.
    always @(negedge clk) begin
        bit want;
        if (!rst) begin
            want = exp_q.size() > 0 && ($time - exp_q[0].t) == 4;
            check("out_valid", 64'(bus.out_valid), 64'(want));
            if (want) cur_out = exp_q.pop_front().val;
            else if (exp_q.size() > 0 && ($time - exp_q[0].t) > 4) void'(exp_q.pop_front());
            check("out", bus.out, cur_out);
            want = err_q.size() > 0 && ($time - err_q[0]) == 4;
            check("frame_err", 64'(bus.frame_err), 64'(want));
            if (want || (err_q.size() > 0 && ($time - err_q[0]) > 4)) void'(err_q.pop_front());
            check("slot", 64'(bus.slot), 64'(coll.size()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        do_rst();

        frame(0, -1, 0);
        check("frame0_out", bus.out, 64'hFEDCBA9876543210);
        check("frame0_slot", 64'(bus.slot), 64'h0);
        idle(2);

        frame(0, 7, 3);
        check("gap_out", bus.out, 64'hFEDCBA9876543210);
        idle(2);

        do_rst();
        for (int k = 0; k < 5; k++) beat(1'b0, 4'(k + 3));
        idle(2);
        check("drop_out", bus.out, 64'h0);
        check_drops();

        beat(1'b1, 4'h7);
        for (int k = 1; k <= 8; k++) beat(1'b0, 4'(k + 7));
        check("slot9", 64'(bus.slot), 64'd9);
        frame(1, -1, 0);
        idle(2);
        check("abort_out", bus.out, 64'h0FEDCBA987654321);
        check_drops();

        beat(1'b1, 4'h5);
        for (int k = 1; k < 6; k++) beat(1'b0, 4'(k));
        do_rst();
        frame(0, -1, 0);
        idle(2);
        check("post_rst_out", bus.out, 64'hFEDCBA9876543210);

        for (int i = 0; i < 500; i++) begin
            bit sof;
            sof = coll.size() == 0 ? ($urandom % 4 != 0) : ($urandom % 24 == 0);
            beat(sof, 4'($urandom));
            if ($urandom % 5 == 0) idle(1 + $urandom % 3);
        end
        idle(3);
        check_drops();

`ifdef TDM_DEMUX16_DROP_CNT_EN
        do_rst();
        for (int k = 0; k < 300; k++) beat(1'b0, 4'(k));
        idle(2);
        check("drop_sat", 64'(bus.drop_cnt), 64'd255);
        check_drops();
`endif

        idle(3);
        check("pending_out", 64'(exp_q.size()), 64'h0);
        check("pending_err", 64'(err_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Time-division demultiplexer: the receive-side counterpart of the 16:1 channel mux.
- Takes a slotted stream (one slot per valid beat, slot 0 flagged by start-of-frame) and distributes beats into 16 channel registers.
- Publishes all 16 channels in parallel once a complete frame has been assembled.
- Sits after the serial link, feeding per-channel consumers.

Parameters:
- DATA_W, 1, bits per slot (per channel).
- NCH, 16, number of channels. Fixed at 16; the slot counter is 4 bits wide.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat qualifier; gaps between beats are allowed.
- in_sof  input  1  marks the beat as slot 0; ignored when in_valid=0.
- in_data  input  DATA_W  slot payload.
- out  output  NCH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]; registered.
- out_valid  output  1  one-cycle pulse when out is updated.
- slot  output  4  index of the next slot expected in RUN state; 0 in HUNT state.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, active-high): state=HUNT, slot=0, shadow=0, out=0, out_valid=0, frame_err=0.
- Reset asserted mid-frame discards the partial frame.
- States: HUNT, RUN.

HUNT state:
- in_valid & in_sof: write in_data to shadow[0]; slot becomes 1; go to RUN.
- in_valid & !in_sof: drop the beat silently; stay in HUNT; no frame_err.

RUN state, on in_valid & !in_sof:
- Write in_data to shadow[slot]; slot increments.
- When slot==15 is written:
  - On the next edge, out = shadow with slot 15 taken directly from in_data.
  - out_valid pulses high for exactly 1 cycle.
  - State returns to HUNT and slot returns to 0.
- Latency: out/out_valid are high the cycle after the slot-15 beat is sampled.

RUN state, on in_valid & in_sof (early SOF):
- frame_err pulses for 1 cycle.
- Partial frame is discarded; out is not updated.
- The beat is taken as slot 0 of a new frame; slot becomes 1; state stays RUN.

General rules:
- in_valid=0: no state change; slot holds; the frame may stall indefinitely.
- out holds its value until the next complete frame; it is never partially updated.
- Shadow registers are not cleared between frames; every slot is overwritten before publication.
- Slot counter arithmetic is 4-bit and never wraps unobserved: the 15→0 transition only occurs via frame completion.

Optional Feature:
- Macro: TDM_DEMUX16_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt (8 bits).
  - Counts beats dropped in HUNT plus frames aborted by early SOF.
  - Saturates at 255 and is cleared by rst.
  - A drop and an abort cannot occur in the same cycle, so the increment is at most 1 per cycle.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - SLOT_W=4, NCH=16.
  - State encoding: HUNT=1'b0, RUN=1'b1.
  - Channel-slice helper constant for the DATA_W stride.
- One sub-module: dec4to16.
  - Combinational one-hot write-enable decoder, slot→16 enables, gated by the beat-accept strobe.
  - Mirrors the mux select tree on the write side.
- Everything else (FSM, counter, shadow, output register) lives in tdm_demux16.

Test Plan:
- Frame 0x0..0xF, DATA_W=4, sof on the first beat, back-to-back beats:
  - out=0xFEDCBA9876543210 one cycle after beat 15.
  - out_valid high exactly 1 cycle.
  - slot returns to 0.
- Same frame with in_valid low for 3 cycles between beats 7 and 8:
  - Identical out; out_valid 3 cycles later than in the back-to-back case.
  - slot holds at 8 during the gap.
- Five beats without sof after reset:
  - All dropped; out stays 0; no out_valid, no frame_err.
  - With the macro: drop_cnt=5.
- sof at slot 9 mid-frame, followed by a full frame 0x1..0x10 (mod 16):
  - frame_err pulses once.
  - Exactly one out_valid, for the new frame; out values come from the new frame only.
- rst asserted asynchronously at slot 6, released, then a full frame:
  - out=0 and slot=0 immediately on assertion.
  - The following frame publishes correctly.
- With the macro, 300 dropped beats:
  - drop_cnt saturates at 255 and stays there.
